// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single result bus into the reorder buffer among
// NUM_REQ functional units. Each unit has a one-entry holding slot, and a
// round-robin scheduler drains one occupied slot per cycle onto the bus.
// A slot may be refilled on the same edge it is granted, so a requester
// that keeps winning can sustain one result per cycle.
//
// state     | meaning
// ----------|------------------------------------------------------------
// slot i    | r_hold_valid[i] set: a result is waiting for the bus
// r_rr_ptr  | slot the next grant search starts from
// r_cdb_*   | registered bus; r_cdb_ready pulses one cycle per result
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    i_clear,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [ID_W*NUM_REQ-1:0] i_req_rob_id,
  input  logic [32*NUM_REQ-1:0]   i_req_value,
  output logic                    o_cdb_ready,
  output logic [ID_W-1:0]         o_cdb_rob_id,
  output logic [31:0]             o_cdb_value,
  output logic [NUM_REQ-1:0]      o_pending,
  output logic                    o_err_zero_id
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CW    = PTR_W + 1;

  logic [NUM_REQ-1:0] r_hold_valid;
  logic [ID_W-1:0]    r_hold_id    [NUM_REQ];
  logic [31:0]        r_hold_value [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_cdb_ready;
  logic [ID_W-1:0]    r_cdb_rob_id;
  logic [31:0]        r_cdb_value;
  logic               r_err_zero_id;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_any;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_accept;

  // Round-robin search starting at r_rr_ptr; the wrap is an explicit compare
  // so non-power-of-two NUM_REQ never lands on a nonexistent slot.
  always_comb begin : p_grant
    logic [CW-1:0] w_sum;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + CW'(k);
      if (w_sum >= CW'(NUM_REQ)) w_sum = w_sum - CW'(NUM_REQ);
      if (!w_grant_any && r_hold_valid[w_sum[PTR_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_sum[PTR_W-1:0];
      end
    end
    if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
  end

  // Pointer moves to the slot after the winner, wrapping by compare.
  always_comb begin
    w_next_ptr = w_grant_idx + PTR_W'(1);
    if (w_grant_idx == PTR_W'(NUM_REQ - 1)) w_next_ptr = '0;
  end

  // A granted slot empties this edge, so it can take a new result at once.
  assign o_req_ready = {NUM_REQ{rdy_in & ~i_clear}} & (~r_hold_valid | w_grant);
  assign w_accept    = i_req_valid & o_req_ready;

  // Slot, pointer and bus registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hold_valid  <= '0;
      r_rr_ptr      <= '0;
      r_cdb_ready   <= 1'b0;
      r_cdb_rob_id  <= '0;
      r_cdb_value   <= '0;
      r_err_zero_id <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_id[i]    <= '0;
        r_hold_value[i] <= '0;
      end
    end else if (rdy_in) begin
      if (i_clear) begin
        r_hold_valid <= '0;
        r_cdb_ready  <= 1'b0;
        r_rr_ptr     <= '0;
      end else begin
        if (w_grant_any) begin
          r_cdb_ready  <= 1'b1;
          r_cdb_rob_id <= r_hold_id[w_grant_idx];
          r_cdb_value  <= r_hold_value[w_grant_idx];
          r_rr_ptr     <= w_next_ptr;
        end else begin
          r_cdb_ready  <= 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w_accept[i]) begin
            // id 0 means "no entry" to the ROB, so such a result is dropped.
            if (i_req_rob_id[i*ID_W +: ID_W] != '0) begin
              r_hold_valid[i] <= 1'b1;
              r_hold_id[i]    <= i_req_rob_id[i*ID_W +: ID_W];
              r_hold_value[i] <= i_req_value[i*32 +: 32];
            end else begin
              r_hold_valid[i] <= 1'b0;
              r_err_zero_id   <= 1'b1;
            end
          end else if (w_grant[i]) begin
            r_hold_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_cdb_ready   = r_cdb_ready;
  assign o_cdb_rob_id  = r_cdb_rob_id;
  assign o_cdb_value   = r_cdb_value;
  assign o_pending     = r_hold_valid;
  assign o_err_zero_id = r_err_zero_id;

endmodule
